// File: rtl/fifo_pop_arbiter_if.sv
// Handshake bundle between the pop arbiter, the input Fifo bank and the downstream Fifo bank.
// The master side is the arbiter; the slave side drives FIFO status and data.
interface fifo_pop_arbiter_if #(
    parameter int data_width = 10
);
    logic [3:0]              fifo_empty;
    logic [4*data_width-1:0] fifo_data;
    logic [3:0]              dest_afull;
    logic [3:0]              pop;
    logic [3:0]              push;
    logic [data_width-1:0]   data_out;
    logic [1:0]              state;
    logic                    idle;

    modport master (
        input  fifo_empty, fifo_data, dest_afull,
        output pop, push, data_out, state, idle
    );

    modport slave (
        output fifo_empty, fifo_data, dest_afull,
        input  pop, push, data_out, state, idle
    );
endinterface

// File: rtl/fifo_pop_arbiter.sv
// Round-robin pop controller: drains four input FIFOs one word per cycle and
// routes each word to the downstream FIFO named by its top two bits.
module fifo_pop_arbiter #(
    parameter int data_width = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    fifo_pop_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_t;

    state_t                state_q;
    logic [1:0]            rr;
    logic [3:0]            pop_q;
    logic [1:0]            pop_src;
    logic [3:0]            push_q;
    logic [data_width-1:0] data_q;
    logic [RD_LATENCY-1:0] pipe_valid;
    logic [1:0]            pipe_src [RD_LATENCY];

    logic [3:0]            eligible;
    logic                  afull;
    logic                  any_pending;
    logic                  in_flight;
    logic                  drained;
    logic                  grant_found;
    logic                  do_grant;
    logic [1:0]            grant_idx;
    logic [1:0]            emerge_src;
    logic [data_width-1:0] emerge_word;

    // The empty flag lags a pop by one cycle, so a FIFO popped this cycle is skipped.
    assign eligible    = ~bus.fifo_empty & ~pop_q;
    assign afull       = |bus.dest_afull;
    assign any_pending = ~&bus.fifo_empty;
    assign in_flight   = (|pop_q) | (|pipe_valid);
    assign drained     = ~any_pending & ~in_flight;
    assign do_grant    = grant_found & ~afull;

    assign emerge_src  = pipe_src[RD_LATENCY-1];
    assign emerge_word = bus.fifo_data[int'(emerge_src)*data_width +: data_width];

    // Descending scan so the eligible FIFO closest to rr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr;
        for (int k = 3; k >= 0; k--) begin
            if (eligible[rr + 2'(k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr + 2'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr         <= 2'd0;
            pop_q      <= 4'b0000;
            pop_src    <= 2'd0;
            push_q     <= 4'b0000;
            data_q     <= '0;
            pipe_valid <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_src[k] <= 2'd0;
            end
        end else begin
            pop_q <= do_grant ? (4'b0001 << grant_idx) : 4'b0000;
            if (do_grant) begin
                pop_src <= grant_idx;
                rr      <= grant_idx + 2'd1;
            end

            pipe_valid[0] <= |pop_q;
            pipe_src[0]   <= pop_src;
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_src[k]   <= pipe_src[k-1];
            end

            // Words in flight are pushed regardless of downstream almost_full.
            if (pipe_valid[RD_LATENCY-1]) begin
                push_q <= 4'b0001 << emerge_word[data_width-1 -: 2];
                data_q <= emerge_word;
            end else begin
                push_q <= 4'b0000;
            end

            case (state_q)
                IDLE: begin
                    if (grant_found && !afull)
                        state_q <= ACTIVE;
                    else if (any_pending && afull)
                        state_q <= STALL;
                end
                ACTIVE: begin
                    if (afull)
                        state_q <= STALL;
                    else if (drained)
                        state_q <= IDLE;
                end
                STALL: begin
                    if (!afull && any_pending)
                        state_q <= ACTIVE;
                    else if (drained)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pop      = pop_q;
    assign bus.push     = push_q;
    assign bus.data_out = data_q;
    assign bus.state    = state_q;
    assign bus.idle     = (state_q == IDLE) && !in_flight;
endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Directed bench for fifo_pop_arbiter: a behavioural input-FIFO bank with a
// two-cycle read latency feeds the DUT, and pops/pushes are logged per cycle.
module tb_fifo_pop_arbiter;
    localparam int DW = 10;
    localparam logic [DW-1:0] JUNK = 10'h1C7;

    typedef struct {
        int         cyc;
        logic [3:0] v;
        logic [9:0] d;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   check_count = 0;
    int   pass_count = 0;

    ev_t        pop_log[$];
    ev_t        push_log[$];
    logic [9:0] fq [4][$];
    logic [9:0] d1 [4];
    logic [9:0] fdata [4];
    logic [3:0] popped;

    logic [3:0] t2_pop_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [9:0] t2_dat_exp [5] = '{10'h011, 10'h121, 10'h231, 10'h341, 10'h012};
    logic [3:0] t2_psh_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    fifo_pop_arbiter_if #(.data_width(DW)) bif ();

    fifo_pop_arbiter #(.data_width(DW), .RD_LATENCY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.master)
    );

    always #5 clk = ~clk;

    // Input FIFO bank: empty updates one cycle after a pop, data shows two cycles after it.
    always @(posedge clk) begin
        popped = bif.pop;
        #1;
        for (int i = 0; i < 4; i++) begin
            fdata[i] = d1[i];
            if (popped[i] && fq[i].size() > 0)
                d1[i] = fq[i].pop_front();
            else
                d1[i] = JUNK;
            bif.fifo_empty[i] = (fq[i].size() == 0);
        end
        bif.fifo_data = {fdata[3], fdata[2], fdata[1], fdata[0]};
    end

    always @(negedge clk) begin
        cyc++;
        if (bif.pop != 4'b0000)
            pop_log.push_back('{cyc, bif.pop, 10'd0});
        if (bif.push != 4'b0000)
            push_log.push_back('{cyc, bif.push, bif.data_out});
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input int fifo, input logic [9:0] word);
        fq[fifo].push_back(word);
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clearLogs();
        pop_log.delete();
        push_log.delete();
    endtask

    task automatic waitPop(input logic [3:0] expected);
        int n = 0;
        while (bif.pop !== expected && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_pop", {28'd0, bif.pop}, {28'd0, expected});
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_pop"},   bif.pop,      4'b0000);
        checkOutput({tag, "_push"},  bif.push,     4'b0000);
        checkOutput({tag, "_data"},  bif.data_out, 10'h000);
        checkOutput({tag, "_state"}, bif.state,    2'd0);
        checkOutput({tag, "_idle"},  bif.idle,     1'b1);
    endtask

    initial begin
        reset = 1'b1;
        bif.dest_afull = 4'b0000;

        // Single word from FIFO0 to destination 2.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkResetOutputs("t1_rst");
        clearLogs();
        applyStimulus(0, 10'h2A5);
        runCycles(15);
        checkOutput("t1_npop", pop_log.size(), 1);
        checkOutput("t1_npush", push_log.size(), 1);
        if (pop_log.size() == 1 && push_log.size() == 1) begin
            checkOutput("t1_pop", pop_log[0].v, 4'b0001);
            checkOutput("t1_push", push_log[0].v, 4'b0100);
            checkOutput("t1_data", push_log[0].d, 10'h2A5);
            checkOutput("t1_lat", push_log[0].cyc - pop_log[0].cyc, 3);
        end
        checkOutput("t1_state", bif.state, 2'd0);
        checkOutput("t1_idle", bif.idle, 1'b1);
        checkOutput("t1_hold", bif.data_out, 10'h2A5);

        // All four FIFOs busy: strict rotation.
        resetDut();
        clearLogs();
        applyStimulus(0, 10'h011);
        applyStimulus(0, 10'h012);
        applyStimulus(1, 10'h121);
        applyStimulus(2, 10'h231);
        applyStimulus(3, 10'h341);
        runCycles(20);
        checkOutput("t2_npop", pop_log.size(), 5);
        checkOutput("t2_npush", push_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < pop_log.size()) begin
                checkOutput($sformatf("t2_pop%0d", k), pop_log[k].v, t2_pop_exp[k]);
                checkOutput($sformatf("t2_popcyc%0d", k), pop_log[k].cyc - pop_log[0].cyc, k);
            end
            if (k < push_log.size() && pop_log.size() > 0) begin
                checkOutput($sformatf("t2_push%0d", k), push_log[k].v, t2_psh_exp[k]);
                checkOutput($sformatf("t2_data%0d", k), push_log[k].d, t2_dat_exp[k]);
                checkOutput($sformatf("t2_pushcyc%0d", k), push_log[k].cyc - pop_log[0].cyc, k + 3);
            end
        end

        // One FIFO with three words: pops every other cycle.
        resetDut();
        clearLogs();
        applyStimulus(2, 10'h2A1);
        applyStimulus(2, 10'h2A2);
        applyStimulus(2, 10'h2A3);
        runCycles(20);
        checkOutput("t3_npop", pop_log.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < pop_log.size()) begin
                checkOutput($sformatf("t3_pop%0d", k), pop_log[k].v, 4'b0100);
                checkOutput($sformatf("t3_popcyc%0d", k), pop_log[k].cyc - pop_log[0].cyc, 2 * k);
            end
            if (k < push_log.size())
                checkOutput($sformatf("t3_data%0d", k), push_log[k].d, 10'h2A1 + k);
        end

        // Backpressure while two pops are in flight, then resume from rr=2.
        resetDut();
        clearLogs();
        applyStimulus(0, 10'h111);
        applyStimulus(0, 10'h100);
        applyStimulus(1, 10'h222);
        applyStimulus(2, 10'h033);
        waitPop(4'b0001);
        @(posedge clk);
        #1;
        bif.dest_afull = 4'b0010;
        runCycles(6);
        checkOutput("t4_state", bif.state, 2'd2);
        checkOutput("t4_idle", bif.idle, 1'b0);
        checkOutput("t4_npop_stall", pop_log.size(), 2);
        checkOutput("t4_npush_stall", push_log.size(), 2);
        bif.dest_afull = 4'b0000;
        runCycles(15);
        checkOutput("t4_npop", pop_log.size(), 4);
        checkOutput("t4_npush", push_log.size(), 4);
        if (pop_log.size() == 4 && push_log.size() == 4) begin
            checkOutput("t4_pop1", pop_log[1].v, 4'b0010);
            checkOutput("t4_pop2", pop_log[2].v, 4'b0100);
            checkOutput("t4_pop3", pop_log[3].v, 4'b0001);
            checkOutput("t4_resume_cyc", pop_log[2].cyc - pop_log[0].cyc, 7);
            checkOutput("t4_push0", {push_log[0].v, push_log[0].d}, {4'b0010, 10'h111});
            checkOutput("t4_push1", {push_log[1].v, push_log[1].d}, {4'b0100, 10'h222});
            checkOutput("t4_push1_cyc", push_log[1].cyc - pop_log[0].cyc, 4);
            checkOutput("t4_push2", {push_log[2].v, push_log[2].d}, {4'b0001, 10'h033});
            checkOutput("t4_push3", {push_log[3].v, push_log[3].d}, {4'b0010, 10'h100});
        end
        checkOutput("t4_final_state", bif.state, 2'd0);

        // Reset one cycle after a pop discards the word and clears rr.
        resetDut();
        clearLogs();
        applyStimulus(1, 10'h1B7);
        waitPop(4'b0010);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkResetOutputs("t5_rst");
        runCycles(8);
        checkOutput("t5_nopush", push_log.size(), 0);
        clearLogs();
        applyStimulus(3, 10'h0C3);
        applyStimulus(0, 10'h1C0);
        runCycles(12);
        checkOutput("t5_npop", pop_log.size(), 2);
        if (pop_log.size() == 2) begin
            checkOutput("t5_rr_first", pop_log[0].v, 4'b0001);
            checkOutput("t5_rr_second", pop_log[1].v, 4'b1000);
        end

        // Extreme words: all-ones to destination 3, all-zeros to destination 0.
        resetDut();
        clearLogs();
        applyStimulus(0, 10'h3FF);
        applyStimulus(0, 10'h000);
        runCycles(15);
        checkOutput("t6_npush", push_log.size(), 2);
        if (push_log.size() == 2) begin
            checkOutput("t6_push0", {push_log[0].v, push_log[0].d}, {4'b1000, 10'h3FF});
            checkOutput("t6_push1", {push_log[1].v, push_log[1].d}, {4'b0001, 10'h000});
            checkOutput("t6_gap", push_log[1].cyc - push_log[0].cyc, 2);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
